vga_timing_gen: RTL and testbench
=================================

Name:
vga_timing_gen

Overview:
- 640x480@60 Hz VGA timing generator driven from a 100 MHz system clock.
- Derives a 25 MHz pixel tick with a divide-by-4 prescaler.
- Runs a horizontal counter (0..799) and a vertical counter (0..524).
- Decodes horizontal sync, vertical sync and the active-video select from the counters using magnitude comparators. The colour/pixel path uses these outputs to time its output.

Parameters:
- DIV, 4, clk100 cycles per pixel tick; power of two, at least 2.
- H_TOTAL, 800, pixel ticks per line; hcount wraps at H_TOTAL-1.
- H_SYNC, 96, HS is high while hcount < H_SYNC.
- H_ACT_START, 144, first active hcount.
- H_ACT_END, 784, first hcount after the active region.
- V_TOTAL, 525, lines per frame; vcount wraps at V_TOTAL-1.
- V_SYNC, 2, VS is high while vcount < V_SYNC.
- V_ACT_START, 35, first active line.
- V_ACT_END, 515, first line after the active region.
- CW, 10, counter width in bits.

Ports:
- clk100  input  1  system clock, 100 MHz; the only clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- HS  output  1  horizontal sync.
- VS  output  1  vertical sync.
- vidSel  output  1  high inside the visible 640x480 window.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low. All state lives in the clk100 domain; no derived clocks are used.
- Reset state: prescaler = 0, hcount = 0, vcount = 0, so HS = 1, VS = 1 and vidSel = 0 while reset is asserted.
- Deasserting reset mid-frame restarts the frame from (0,0).
- Prescaler:
  - 2-bit counter that increments every clk100 cycle and wraps.
  - pix_tick = 1 when prescaler == DIV-1, i.e. one cycle in four.
- Horizontal counter:
  - On pix_tick it increments.
  - On pix_tick with hcount == H_TOTAL-1, it clears to 0; tc_h = that condition.
- Vertical counter:
  - Advances only on tc_h (the end-of-line tick).
  - Clears to 0 when tc_h and vcount == V_TOTAL-1.
  - hcount and vcount wrap on the same clk100 edge at end of frame.
- Comparator: a reusable unsigned CW-bit "a < b" unit. Every decode uses strict less-than against a constant.
- Output decode (combinational from the registered counters, no extra latency):
  - HS = (hcount < H_SYNC).
  - VS = (vcount < V_SYNC).
  - vidSel = !(hcount < H_ACT_START) & (hcount < H_ACT_END) & !(vcount < V_ACT_START) & (vcount < V_ACT_END).
- Timing:
  - Line = 800 ticks = 3200 clk100 cycles.
  - Frame = 525 lines = 1,680,000 clk100 cycles.
  - HS high for 384 clk100 cycles per line.
  - VS high for 2 lines = 6400 cycles.
- Counters never exceed TOTAL-1; no other overflow path exists.
- The first hcount increment occurs on the 4th rising edge after reset is released.

Optional Feature:
- SYNC_ACTIVE_LOW_EN
  - Defined: HS and VS are inverted, giving the standard VGA negative sync polarity. During reset HS = 0 and VS = 0. The vidSel decode and all counter behaviour are unchanged.
  - Undefined: HS and VS are active-high exactly as described in Behaviour.

Test Plan:
1. Hold reset=0 for 5 cycles -> HS=1, VS=1, vidSel=0. Release: hcount becomes 1 on the 4th edge. HS falls after 96 ticks (384 clk100 cycles from the first tick).
2. Run one line (3200 cycles) -> hcount 799 wraps to 0 and vcount 0 goes to 1 on the same edge. HS rises again at hcount 0.
3. Line 40 (active region) -> vidSel rises when hcount becomes 144, falls when hcount becomes 784; vidSel=0 on lines 0..34 and 515..524.
4. Full frame of 1,680,000 cycles -> VS high only for vcount 0..1. Both counters return to (0,0) exactly 1,680,000 cycles after the first tick alignment; the second frame repeats identically.
5. Assert reset mid-frame at (hcount=500, vcount=300) -> counters clear immediately, without waiting for a clock edge, and outputs return to reset values.
6. Compile with SYNC_ACTIVE_LOW_EN -> HS and VS are the exact complements of scenarios 1-4; vidSel is unchanged.

Source files
------------

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA timing from a 100 MHz clock: divide-by-DIV pixel tick, h/v counters, sync/active decode.
// Latency: HS/VS/vidSel are combinational from the registered counters (no extra cycle); no backpressure.
// Build option SYNC_ACTIVE_LOW_EN inverts HS and VS for negative sync polarity.

module vga_lt #(
    parameter int CW = 10
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    output logic          lt
);
    assign lt = (a < b);
endmodule

module vga_timing_gen #(
    parameter int DIV         = 4,
    parameter int H_TOTAL     = 800,
    parameter int H_SYNC      = 96,
    parameter int H_ACT_START = 144,
    parameter int H_ACT_END   = 784,
    parameter int V_TOTAL     = 525,
    parameter int V_SYNC      = 2,
    parameter int V_ACT_START = 35,
    parameter int V_ACT_END   = 515,
    parameter int CW          = 10
) (
    input  logic clk100,
    input  logic reset,
    output logic HS,
    output logic VS,
    output logic vidSel
);
    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0] prescaler;
    logic [CW-1:0] hcount;
    logic [CW-1:0] vcount;
    logic          pix_tick;
    logic          tc_h;
    logic          tc_v;

    assign pix_tick = (prescaler == PW'(DIV - 1));
    assign tc_h     = pix_tick && (hcount == CW'(H_TOTAL - 1));
    assign tc_v     = tc_h && (vcount == CW'(V_TOTAL - 1));

    // DIV is a power of two, so the prescaler wraps naturally.
    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            hcount <= '0;
        end else if (tc_h) begin
            hcount <= '0;
        end else if (pix_tick) begin
            hcount <= hcount + CW'(1);
        end
    end

    always_ff @(posedge clk100 or negedge reset) begin
        if (!reset) begin
            vcount <= '0;
        end else if (tc_v) begin
            vcount <= '0;
        end else if (tc_h) begin
            vcount <= vcount + CW'(1);
        end
    end

    logic h_sync_lt, h_beg_lt, h_end_lt;
    logic v_sync_lt, v_beg_lt, v_end_lt;

    vga_lt #(.CW(CW)) u_h_sync (.a(hcount), .b(CW'(H_SYNC)),      .lt(h_sync_lt));
    vga_lt #(.CW(CW)) u_h_beg  (.a(hcount), .b(CW'(H_ACT_START)), .lt(h_beg_lt));
    vga_lt #(.CW(CW)) u_h_end  (.a(hcount), .b(CW'(H_ACT_END)),   .lt(h_end_lt));
    vga_lt #(.CW(CW)) u_v_sync (.a(vcount), .b(CW'(V_SYNC)),      .lt(v_sync_lt));
    vga_lt #(.CW(CW)) u_v_beg  (.a(vcount), .b(CW'(V_ACT_START)), .lt(v_beg_lt));
    vga_lt #(.CW(CW)) u_v_end  (.a(vcount), .b(CW'(V_ACT_END)),   .lt(v_end_lt));

    assign vidSel = !h_beg_lt && h_end_lt && !v_beg_lt && v_end_lt;

`ifdef SYNC_ACTIVE_LOW_EN
    assign HS = ~h_sync_lt;
    assign VS = ~v_sync_lt;
`else
    assign HS = h_sync_lt;
    assign VS = v_sync_lt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: full-size DUT plus a scaled-down DUT (so whole frames fit the run), both checked every cycle
// against an elapsed-cycle model, with random asynchronous resets.
`timescale 1ns/1ps

module tb_vga_timing_gen;

`ifdef SYNC_ACTIVE_LOW_EN
    localparam bit INV = 1'b1;
`else
    localparam bit INV = 1'b0;
`endif

    // Scaled timing: 40 ticks/line, 20 lines/frame, DIV=2 -> 1600 cycles per frame.
    localparam int S_DIV = 2, S_HT = 40, S_HS = 5, S_HA = 8, S_HE = 36;
    localparam int S_VT = 20, S_VS = 2, S_VA = 4, S_VE = 17;
    localparam int S_FRAME = S_DIV * S_HT * S_VT;

    logic clk100 = 1'b0;
    logic reset  = 1'b0;
    logic hs_d, vs_d, vid_d;
    logic hs_s, vs_s, vid_s;

    int checks = 0;
    int errors = 0;
    int k = 0;  // rising edges since reset release

    always #5 clk100 = ~clk100;

    vga_timing_gen u_dut_full (
        .clk100 (clk100),
        .reset  (reset),
        .HS     (hs_d),
        .VS     (vs_d),
        .vidSel (vid_d)
    );

    vga_timing_gen #(
        .DIV(S_DIV), .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HA), .H_ACT_END(S_HE),
        .V_TOTAL(S_VT), .V_SYNC(S_VS), .V_ACT_START(S_VA), .V_ACT_END(S_VE), .CW(10)
    ) u_dut_small (
        .clk100 (clk100),
        .reset  (reset),
        .HS     (hs_s),
        .VS     (vs_s),
        .vidSel (vid_s)
    );

    always @(posedge clk100 or negedge reset) begin
        if (!reset) k = 0;
        else        k = k + 1;
    end

    // Expected {HS, VS, vidSel} (active-high) after n edges of free running.
    function automatic logic [2:0] model(int n, int div, int ht, int hsy, int ha, int he,
                                         int vt, int vsy, int va, int ve);
        int ticks, h, v;
        ticks = n / div;
        h = ticks % ht;
        v = (ticks / ht) % vt;
        return {h < hsy, v < vsy, (h >= ha) && (h < he) && (v >= va) && (v < ve)};
    endfunction

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t k=%0d)", name, got, exp, $time, k);
        end
    endtask

    always @(negedge clk100) begin
        logic [2:0] ef, es;
        ef = model(k, 4, 800, 96, 144, 784, 525, 2, 35, 515);
        es = model(k, S_DIV, S_HT, S_HS, S_HA, S_HE, S_VT, S_VS, S_VA, S_VE);
        check("full_HS",     int'(hs_d),  int'(ef[2] ^ INV));
        check("full_VS",     int'(vs_d),  int'(ef[1] ^ INV));
        check("full_vidSel", int'(vid_d), int'(ef[0]));
        check("small_HS",    int'(hs_s),  int'(es[2] ^ INV));
        check("small_VS",    int'(vs_s),  int'(es[1] ^ INV));
        check("small_vidSel",int'(vid_s), int'(es[0]));
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_full_HS"},   int'(hs_d),  int'(1'b1 ^ INV));
        check({tag, "_full_VS"},   int'(vs_d),  int'(1'b1 ^ INV));
        check({tag, "_full_vid"},  int'(vid_d), 0);
        check({tag, "_small_HS"},  int'(hs_s),  int'(1'b1 ^ INV));
        check({tag, "_small_VS"},  int'(vs_s),  int'(1'b1 ^ INV));
        check({tag, "_small_vid"}, int'(vid_s), 0);
    endtask

    task automatic release_reset();
        @(posedge clk100);
        #2 reset = 1'b1;
    endtask

    initial begin
        int hs_cnt, hs_fall;
        int vs_cnt[2];
        int vid_cnt[2];
        int first_vid[2];
        int hs_line1;
        int waited;
        bit found;

        reset = 1'b0;
        repeat (5) @(negedge clk100);
        check_reset_vals("reset_hold");
        release_reset();

        hs_cnt = 0; hs_fall = -1; hs_line1 = 0;
        for (int f = 0; f < 2; f++) begin
            vs_cnt[f] = 0; vid_cnt[f] = 0; first_vid[f] = -1;
        end
        for (int i = 0; i < 2 * S_FRAME + 10; i++) begin
            @(negedge clk100);
            if (k < 3200) begin
                hs_cnt += int'(hs_d ^ INV);
                if (hs_fall < 0 && !(hs_d ^ INV)) hs_fall = k;
            end else if (k < 3200 + 4) begin
                hs_line1 += int'(hs_d ^ INV);
            end
            if (k < 2 * S_FRAME) begin
                vs_cnt[k / S_FRAME]  += int'(vs_s ^ INV);
                vid_cnt[k / S_FRAME] += int'(vid_s);
                if (vid_s && first_vid[k / S_FRAME] < 0) first_vid[k / S_FRAME] = k % S_FRAME;
            end
        end
        check("full_hs_high_cycles_line0", hs_cnt, 384);
        check("full_hs_fall_edge", hs_fall, 384);
        check("full_hs_high_line1_start", hs_line1, 4);
        for (int f = 0; f < 2; f++) begin
            check($sformatf("small_vs_cycles_frame%0d", f), vs_cnt[f], 160);
            check($sformatf("small_vid_cycles_frame%0d", f), vid_cnt[f], 728);
            check($sformatf("small_first_vid_frame%0d", f), first_vid[f], 336);
        end

        // Mid-frame asynchronous reset at small-DUT (h=25, v=12).
        found = 1'b0;
        waited = 0;
        while (!found && waited < 2 * S_FRAME) begin
            @(negedge clk100);
            waited++;
            if (k % S_FRAME == S_DIV * (12 * S_HT + 25)) found = 1'b1;
        end
        check("midframe_reached", int'(found), 1);
        check("midframe_pre_small_vid", int'(vid_s), 1);
        @(posedge clk100);
        #2 reset = 1'b0;
        #1 check_reset_vals("midframe_async");
        repeat (3) @(negedge clk100);
        release_reset();

        for (int it = 0; it < 15; it++) begin
            repeat ($urandom_range(4000, 50)) @(posedge clk100);
            #($urandom_range(3, 1)) reset = 1'b0;
            #1 check_reset_vals($sformatf("rand_async%0d", it));
            repeat ($urandom_range(5, 1)) @(negedge clk100);
            release_reset();
        end
        repeat (10) @(negedge clk100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
